// File: rtl/filter_bank_pkg.sv
// Shared types and constants for the filter bank sequencer: bank codes,
// the bank-code width and the sequencer state encoding.
package filter_bank_pkg;

  localparam int BANK_W = 2;

  typedef logic [BANK_W-1:0] bank_t;

  localparam bank_t BANK_BYPASS = 2'd0;
  localparam bank_t BANK_1      = 2'd1;
  localparam bank_t BANK_2      = 2'd2;
  localparam bank_t BANK_3      = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_DOWN,
    SWITCH,
    FLUSH,
    RAMP_UP
  } seq_state_t;

  // Width of a gain word able to hold 0..ramp_steps inclusive.
  function automatic int gain_width(input int ramp_steps);
    return $clog2(ramp_steps) + 1;
  endfunction

endpackage

// File: rtl/filter_bank_sequencer_if.sv
// Bundle between the bank-select coordinator (master) and the sequencer
// (slave): sample strobe and bank request in, routing/gain/clear status out.
interface filter_bank_sequencer_if #(
  parameter int GW = 5
);
  import filter_bank_pkg::*;

  logic          sample_strobe;
  bank_t         bank_request;
  bank_t         bank_active;
  logic [GW-1:0] gain;
  logic          filter_clear;
  logic          busy;

  modport master (
    output sample_strobe, bank_request,
    input  bank_active, gain, filter_clear, busy
  );

  modport slave (
    input  sample_strobe, bank_request,
    output bank_active, gain, filter_clear, busy
  );

endinterface

// File: rtl/filter_bank_sequencer_strobe_counter.sv
// Counts sample strobes while enabled. 'done' fires combinationally on the
// strobe that completes the TERMINAL-th count, so the owner can leave its
// waiting state on that same edge. A strobe arriving while disabled is
// ignored entirely.
module strobe_counter #(
  parameter int TERMINAL = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic sample_strobe,
  output logic done
);
  localparam int TERM = (TERMINAL > 0) ? TERMINAL : 1;
  localparam int CW   = (TERM > 1) ? $clog2(TERM) : 1;
  localparam logic [CW-1:0] LAST = CW'(TERM - 1);

  logic [CW-1:0] count;

  // Strobe count, held once the last slot is reached until the next clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && sample_strobe && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign done = enable && sample_strobe && (count == LAST);

endmodule

// File: rtl/filter_bank_sequencer.sv
// Glitch-free bank changer: fades the output gain to zero, swaps the routed
// bank while muted, clears and refills the new bank's delay line, then fades
// back in. Gain and flush timing advance on sample strobes, not clocks.
module filter_bank_sequencer
  import filter_bank_pkg::*;
#(
  parameter int RAMP_STEPS    = 16,
  parameter int FLUSH_SAMPLES = 32
) (
  input logic                    clk,
  input logic                    reset,
  filter_bank_sequencer_if.slave bus
);
  localparam int GW = gain_width(RAMP_STEPS);
  localparam logic [GW-1:0] GAIN_FULL = GW'(RAMP_STEPS);

  seq_state_t    state, state_next;
  logic [GW-1:0] gain_q, gain_next;
  bank_t         active_q, active_next;
  logic          clear_q, clear_next;
  logic          mismatch;
  logic          flush_done;

  generate
    if (FLUSH_SAMPLES > 0) begin : g_flush
      strobe_counter #(
        .TERMINAL(FLUSH_SAMPLES)
      ) u_flush_counter (
        .clk          (clk),
        .reset        (reset),
        .enable       (state == FLUSH),
        .clear        (state == SWITCH),
        .sample_strobe(bus.sample_strobe),
        .done         (flush_done)
      );
    end else begin : g_no_flush
      assign flush_done = 1'b0;
    end
  endgenerate

  // State and all outputs are registered so nothing combinational reaches the ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gain_q   <= GAIN_FULL;
      active_q <= BANK_BYPASS;
      clear_q  <= 1'b0;
    end else begin
      state    <= state_next;
      gain_q   <= gain_next;
      active_q <= active_next;
      clear_q  <= clear_next;
    end
  end

  // Next-state and next-output decode; a withdrawn or changed request reverses the fade at the current gain.
  always_comb begin
    state_next  = state;
    gain_next   = gain_q;
    active_next = active_q;
    clear_next  = 1'b0;
    mismatch    = (bus.bank_request != active_q);
    unique case (state)
      IDLE: begin
        if (mismatch) state_next = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (!mismatch) begin
          state_next = RAMP_UP;
        end else if (gain_q == '0) begin
          state_next = SWITCH;
        end else if (bus.sample_strobe) begin
          gain_next = gain_q - GW'(1);
        end
      end
      SWITCH: begin
        gain_next   = '0;
        active_next = bus.bank_request;
        clear_next  = 1'b1;
        state_next  = (FLUSH_SAMPLES == 0) ? RAMP_UP : FLUSH;
      end
      FLUSH: begin
        gain_next = '0;
        if (flush_done) state_next = RAMP_UP;
      end
      RAMP_UP: begin
        if (mismatch) begin
          state_next = RAMP_DOWN;
        end else if (gain_q == GAIN_FULL) begin
          state_next = IDLE;
        end else if (bus.sample_strobe) begin
          gain_next = gain_q + GW'(1);
          if (gain_q == GAIN_FULL - GW'(1)) state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.gain         = gain_q;
  assign bus.bank_active  = active_q;
  assign bus.filter_clear = clear_q;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_filter_bank_sequencer.sv
// Bench for filter_bank_sequencer: one instance with a 3-strobe flush and one
// with no flush, both RAMP_STEPS=4, sharing clock, reset and strobe. Every
// clock both are compared with a phase-level reference model; directed
// scenarios add checks on gain trajectories, clear pulses and strobe counts.
module tb_filter_bank_sequencer;
  import filter_bank_pkg::*;

  localparam int RS = 4;
  localparam int GW = 3;

  localparam int P_REST   = 0;
  localparam int P_FADE   = 1;
  localparam int P_SWAP   = 2;
  localparam int P_SETTLE = 3;
  localparam int P_RISE   = 4;

  logic clk = 1'b0;
  logic reset;

  filter_bank_sequencer_if #(.GW(GW)) bus_a ();
  filter_bank_sequencer_if #(.GW(GW)) bus_b ();

  filter_bank_sequencer #(.RAMP_STEPS(RS), .FLUSH_SAMPLES(3)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  filter_bank_sequencer #(.RAMP_STEPS(RS), .FLUSH_SAMPLES(0)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit    stb;
  bank_t req [2];
  int    cyc;
  bit    inject;
  bit    rand_strobe;

  assign bus_a.sample_strobe = stb;
  assign bus_b.sample_strobe = stb;
  assign bus_a.bank_request  = req[0];
  assign bus_b.bank_request  = req[1];

  logic [1:0]    obs_active [2];
  logic [GW-1:0] obs_gain   [2];
  logic          obs_clear  [2];
  logic          obs_busy   [2];

  assign obs_active[0] = bus_a.bank_active;
  assign obs_gain[0]   = bus_a.gain;
  assign obs_clear[0]  = bus_a.filter_clear;
  assign obs_busy[0]   = bus_a.busy;
  assign obs_active[1] = bus_b.bank_active;
  assign obs_gain[1]   = bus_b.gain;
  assign obs_clear[1]  = bus_b.filter_clear;
  assign obs_busy[1]   = bus_b.busy;

  // Reference model: phase of the bank change, gain level, routed bank,
  // clear pulse and strobes still owed to the flush.
  int m_phase  [2];
  int m_gain   [2];
  int m_active [2];
  int m_clear  [2];
  int m_left   [2];
  int flush_cfg [2] = '{3, 0};

  int gain_log [$];

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i]  = P_REST;
      m_gain[i]   = RS;
      m_active[i] = 0;
      m_clear[i]  = 0;
      m_left[i]   = 0;
    end
  endtask

  task automatic modelStep(input int i, input int r, input bit s);
    m_clear[i] = 0;
    case (m_phase[i])
      P_REST: begin
        if (r != m_active[i]) m_phase[i] = P_FADE;
      end
      P_FADE: begin
        if (r == m_active[i]) m_phase[i] = P_RISE;
        else if (m_gain[i] == 0) m_phase[i] = P_SWAP;
        else if (s) m_gain[i] = m_gain[i] - 1;
      end
      P_SWAP: begin
        m_active[i] = r;
        m_clear[i]  = 1;
        m_left[i]   = flush_cfg[i];
        m_phase[i]  = (flush_cfg[i] == 0) ? P_RISE : P_SETTLE;
      end
      P_SETTLE: begin
        if (s) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) m_phase[i] = P_RISE;
        end
      end
      default: begin
        if (r != m_active[i]) m_phase[i] = P_FADE;
        else if (m_gain[i] == RS) m_phase[i] = P_REST;
        else if (s) begin
          m_gain[i] = m_gain[i] + 1;
          if (m_gain[i] == RS) m_phase[i] = P_REST;
        end
      end
    endcase
  endtask

  task automatic checkOne(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input int i);
    checkOne($sformatf("u%0d.gain@%0d", i, cyc), int'(obs_gain[i]), m_gain[i]);
    checkOne($sformatf("u%0d.bank_active@%0d", i, cyc), int'(obs_active[i]), m_active[i]);
    checkOne($sformatf("u%0d.filter_clear@%0d", i, cyc), int'(obs_clear[i]), m_clear[i]);
    checkOne($sformatf("u%0d.busy@%0d", i, cyc), int'(obs_busy[i]), int'(m_phase[i] != P_REST));
  endtask

  // One clock: pick the strobe, clock both DUTs and the model, compare.
  task automatic applyStimulus();
    if (rand_strobe) stb = ($urandom_range(0, 2) == 0);
    else stb = ((cyc % 4) == 3) || (inject && (m_phase[0] == P_SWAP));
    @(posedge clk);
    for (int i = 0; i < 2; i++) modelStep(i, int'(req[i]), stb);
    #1;
    checkOutput(0);
    checkOutput(1);
    cyc++;
  endtask

  task automatic checkLog(input string tag, input int expected[$]);
    checkOne({tag, ".steps"}, gain_log.size(), expected.size());
    for (int k = 0; k < expected.size() && k < gain_log.size(); k++)
      checkOne($sformatf("%s.step%0d", tag, k), gain_log[k], expected[k]);
  endtask

  // Issue a request on instance sel and run until it returns to rest.
  // alt_mode 1: switch request to alt_req when gain first reads 2.
  // alt_mode 2: switch request to alt_req when the first clear is seen.
  task automatic runSequence(input int sel, input bank_t first_req, input int alt_mode,
                             input bank_t alt_req, output int clears,
                             output int strobes_busy, output int post_clear_strobes);
    int  prev_gain;
    int  guard;
    bit  alt_done;
    bit  after_clear;
    bit  was_busy;
    gain_log.delete();
    clears             = 0;
    strobes_busy       = 0;
    post_clear_strobes = 0;
    alt_done           = 0;
    after_clear        = 0;
    guard              = 0;
    prev_gain          = int'(obs_gain[sel]);
    req[sel]           = first_req;
    do begin
      was_busy = obs_busy[sel];
      applyStimulus();
      if (was_busy && stb) strobes_busy++;
      if (after_clear && stb && prev_gain == 0) post_clear_strobes++;
      if (obs_clear[sel]) begin
        clears++;
        if (!after_clear && alt_mode == 2 && !alt_done) begin
          req[sel] = alt_req;
          alt_done = 1;
        end
        after_clear = 1;
      end
      if (int'(obs_gain[sel]) != prev_gain) gain_log.push_back(int'(obs_gain[sel]));
      prev_gain = int'(obs_gain[sel]);
      if (alt_mode == 1 && !alt_done && prev_gain == 2) begin
        req[sel] = alt_req;
        alt_done = 1;
      end
      guard++;
    end while (obs_busy[sel] && guard < 400);
    checkOne($sformatf("u%0d.settled", sel), int'(obs_busy[sel]), 0);
  endtask

  int q_full [$];
  int q_withdraw [$];
  int clears, sbusy, pclear;

  initial begin
    q_full     = '{3, 2, 1, 0, 1, 2, 3, 4};
    q_withdraw = '{3, 2, 3, 4};
    reset       = 1'b1;
    stb         = 1'b0;
    req[0]      = BANK_BYPASS;
    req[1]      = BANK_BYPASS;
    cyc         = 0;
    inject      = 1'b0;
    rand_strobe = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput(0);
    checkOutput(1);
    checkOne("reset.gain", int'(obs_gain[0]), RS);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] request 0->1 withdrawn at gain 2");
    runSequence(0, BANK_1, 1, BANK_BYPASS, clears, sbusy, pclear);
    checkLog("withdraw", q_withdraw);
    checkOne("withdraw.clears", clears, 0);
    checkOne("withdraw.bank", int'(obs_active[0]), 0);

    $display("[TB] request 0->2 full switch");
    runSequence(0, BANK_2, 0, BANK_2, clears, sbusy, pclear);
    checkLog("switch2", q_full);
    checkOne("switch2.clears", clears, 1);
    checkOne("switch2.flush_strobes", pclear, 4);
    checkOne("switch2.bank", int'(obs_active[0]), 2);

    $display("[TB] request 2->0 with a strobe in the swap clock");
    inject = 1'b1;
    runSequence(0, BANK_BYPASS, 0, BANK_BYPASS, clears, sbusy, pclear);
    inject = 1'b0;
    checkOne("swapstrobe.clears", clears, 1);
    checkOne("swapstrobe.flush_strobes", pclear, 4);
    checkOne("swapstrobe.bank", int'(obs_active[0]), 0);

    $display("[TB] request 0->3 then 3->1 during flush");
    runSequence(0, BANK_3, 2, BANK_1, clears, sbusy, pclear);
    checkLog("retarget", q_full);
    checkOne("retarget.clears", clears, 2);
    checkOne("retarget.bank", int'(obs_active[0]), 1);

    $display("[TB] reset during flush");
    req[0] = BANK_2;
    for (int k = 0; k < 200 && !obs_clear[0]; k++) applyStimulus();
    checkOne("rstflush.clear_seen", int'(obs_clear[0]), 1);
    applyStimulus();
    applyStimulus();
    checkOne("rstflush.bank_before", int'(obs_active[0]), 2);
    #1;
    reset = 1'b1;
    #1;
    req[0] = BANK_BYPASS;
    modelReset();
    checkOutput(0);
    checkOutput(1);
    checkOne("rstflush.gain", int'(obs_gain[0]), RS);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] no-flush build request 0->1");
    runSequence(1, BANK_1, 0, BANK_1, clears, sbusy, pclear);
    checkLog("noflush", q_full);
    checkOne("noflush.clears", clears, 1);
    checkOne("noflush.strobes", sbusy, 8);
    checkOne("noflush.bank", int'(obs_active[1]), 1);

    $display("[TB] randomized requests and strobes");
    rand_strobe = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 29) == 0) req[i] = bank_t'($urandom_range(0, 3));
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter_bank_sequencer.md
# filter_bank_sequencer

Sequences glitch-free changes of the active audio filter bank. It sits between the bank-select coordinator and the FIR filter banks. On a new bank request it ramps the output gain to zero and switches banks. It then clears the new bank's delay line, waits for the pipeline to refill, and ramps the gain back up. All gain and flush timing counts audio sample strobes, not clocks.

## Interface
- `RAMP_STEPS`, default 16: gain steps from full scale to mute. Must be a power of two, ≥2.
- `FLUSH_SAMPLES`, default 32: sample strobes to wait after clearing the new bank (filter tap count). 0 means no wait.
- `clk` input 1: system clock. Single clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `sample_strobe` input 1: one-clk pulse per audio sample.
- `bank_request` input 2: requested bank (0 = bypass, 1..3 = filter banks). Registered upstream.
- `bank_active` output 2: bank currently routed to the output mux.
- `gain` output GW = $clog2(RAMP_STEPS)+1: output gain, 0..RAMP_STEPS. Downstream computes sample*gain >> $clog2(RAMP_STEPS).
- `filter_clear` output 1: one-clk pulse that zeroes the delay line of `bank_active`.
- `busy` output 1: high in every state except IDLE.

## Operation
- Reset values: state IDLE, `bank_active`=0, `gain`=RAMP_STEPS, `filter_clear`=0, `busy`=0, flush count 0.
- IDLE: if `bank_request` != `bank_active`, go to RAMP_DOWN next clk. Otherwise stay.
- RAMP_DOWN: on each strobe, `gain` decrements by 1.
  - When `gain` is 0, go to SWITCH next clk, with no strobe needed.
  - If `bank_request` == `bank_active` (request withdrawn), go to RAMP_UP at the current gain.
- SWITCH: lasts one clk.
  - `bank_active` <= `bank_request` as sampled in this clk.
  - `filter_clear`=1 for this clk only.
  - Flush count cleared.
  - Next state is FLUSH, or RAMP_UP if FLUSH_SAMPLES=0.
- FLUSH: `gain` is held at 0. Count strobes; after the FLUSH_SAMPLES-th strobe, go to RAMP_UP. Changes on `bank_request` are ignored here.
- RAMP_UP: on each strobe, `gain` increments by 1. When `gain` reaches RAMP_STEPS, go to IDLE. If `bank_request` != `bank_active`, go to RAMP_DOWN and keep the current gain.
- Gain arithmetic is saturating: it never goes below 0 or above RAMP_STEPS.
- A strobe that lands in the SWITCH clk is neither counted nor applied.
- A request returning to the old bank during FLUSH completes the in-progress switch. The return is then handled from RAMP_UP as a new mismatch.
- Reset asserted mid-sequence: all outputs return to reset values immediately, which is the asynchronous behaviour. Bank 0 is then active at full gain.

## Timing
- All outputs are registered. No combinational paths from input to output.
- Request to leaving IDLE: 1 clk.
- First gain change: at the first strobe after entering RAMP_DOWN.
- Full switch latency, with no interruptions: RAMP_STEPS strobes + 1 clk + FLUSH_SAMPLES strobes + RAMP_STEPS strobes.
- `bank_active` changes only in the SWITCH clk, and only when `gain`=0. The output mux therefore never switches while audible.
- `filter_clear` is coincident with the `bank_active` update.

## Structure
- Shared package `filter_bank_pkg` holds:
  - the state enum IDLE/RAMP_DOWN/SWITCH/FLUSH/RAMP_UP;
  - bank code constants BANK_BYPASS=0, BANK_1..BANK_3;
  - the bank-code width (2).
- One sub-module, `strobe_counter`: counts `sample_strobe` pulses while enabled, has a synchronous clear, and flags when the count reaches a terminal value. It is used for FLUSH. The gain register stays in the top FSM.

## Test plan
Bench settings for all scenarios: RAMP_STEPS=4, FLUSH_SAMPLES=3, one strobe every 4 clks.
- Reset, then a 0→2 request.
  - `gain` steps 4,3,2,1,0, then one `filter_clear` pulse with `bank_active`=2.
  - Three strobes at `gain`=0, then `gain` steps 1,2,3,4; `busy` drops when `gain`=4.
- Request 0→1, then back to 0 while RAMP_DOWN is at `gain`=2: the FSM ramps up 3,4, with no `filter_clear` and `bank_active` staying 0.
- Request 0→3, then 3→1 during FLUSH: the switch to 3 completes to `gain`=0 in RAMP_UP. That mismatch triggers an immediate SWITCH to 1 with a second `filter_clear`.
- A strobe coinciding with the SWITCH clk: the flush still needs 3 further strobes.
- `reset` asserted during FLUSH with `bank_active`=2: the same clk shows `bank_active`=0, `gain`=4, `busy`=0, `filter_clear`=0.
- FLUSH_SAMPLES=0 build: SWITCH goes directly to RAMP_UP, and total latency is 8 strobes + 1 clk.
